seg_scan_bcd: RTL

SEG_SCAN_BCD -- requirements
Module: seg_scan_bcd

---
 rtl/seg_scan_bcd_pkg.sv | 39 +++
 rtl/seg_scan_bcd_bin2bcd.sv | 72 +++++++
 rtl/seg_scan_bcd.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/seg_scan_bcd_pkg.sv
// Shared segment definitions for seg_scan_bcd: parameter limits, converter
// state encodings and the 7-segment code table.
package seg_scan_bcd_pkg;

  localparam int N_DIG_MIN  = 1;
  localparam int N_DIG_MAX  = 8;
  localparam int DATA_W_MIN = 4;
  localparam int DATA_W_MAX = 27;
  localparam int DIV_MIN    = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } conv_state_t;

  // Segment vectors are packed {a,b,c,d,e,f,g}, a in the MSB.
  localparam logic [6:0] SEG_OFF   = 7'b000_0000;
  localparam logic [6:0] SEG_MINUS = 7'b000_0001;

  function automatic logic [6:0] seg_code(input logic [3:0] digit);
    logic [6:0] code;
    case (digit)
      4'd0:    code = 7'b111_1110;
      4'd1:    code = 7'b011_0000;
      4'd2:    code = 7'b110_1101;
      4'd3:    code = 7'b111_1001;
      4'd4:    code = 7'b011_0011;
      4'd5:    code = 7'b101_1011;
      4'd6:    code = 7'b101_1111;
      4'd7:    code = 7'b111_0000;
      4'd8:    code = 7'b111_1111;
      4'd9:    code = 7'b111_1011;
      default: code = SEG_OFF;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/seg_scan_bcd_bin2bcd.sv
// Sequential double-dabble converter. A start pulse loads the binary value;
// DATA_W shift steps follow, then done pulses for one cycle with the result
// held stable. One nibble above the displayed digits plus a sticky carry-out
// flag detect values that do not fit in N_DIG digits.
module seg_scan_bcd_bin2bcd #(
  parameter int N_DIG  = 2,
  parameter int DATA_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic [DATA_W-1:0]    value_i,
  output logic                 done_o,
  output logic [4*N_DIG-1:0]   bcd_o,
  output logic                 ovf_o
);

  localparam int BCD_W = 4*N_DIG + 4;
  localparam int CNT_W = $clog2(DATA_W + 1);

  logic [DATA_W-1:0] bin_q;
  logic [BCD_W-1:0]  bcd_q;
  logic [BCD_W-1:0]  bcd_adj;
  logic [CNT_W-1:0]  cnt_q;
  logic              run_q;
  logic              done_q;
  logic              lost_q;

  // Add-3 correction on every nibble that is 5 or more before the shift.
  always_comb begin
    bcd_adj = bcd_q;
    for (int k = 0; k < N_DIG + 1; k++) begin
      if (bcd_q[4*k +: 4] >= 4'd5) begin
        bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
      end
    end
  end

  // Load on start, then shift DATA_W times; a bit leaving the top is sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q  <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
      lost_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start_i) begin
        bin_q  <= value_i;
        bcd_q  <= '0;
        cnt_q  <= CNT_W'(DATA_W);
        run_q  <= 1'b1;
        lost_q <= 1'b0;
      end else if (run_q) begin
        {bcd_q, bin_q} <= {bcd_adj[BCD_W-2:0], bin_q, 1'b0};
        lost_q         <= lost_q | bcd_adj[BCD_W-1];
        cnt_q          <= cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          run_q  <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign done_o = done_q;
  assign bcd_o  = bcd_q[4*N_DIG-1:0];
  assign ovf_o  = lost_q | (bcd_q[BCD_W-1 -: 4] != 4'd0);

endmodule

// File: rtl/seg_scan_bcd.sv
// Binary-to-7-segment multiplexed display driver. A converter FSM turns
// data_in into BCD whenever it changes; a scan tick steps through the digits
// driving one-cold digit selects and registered segment lines.
//
// state    | meaning
// ST_IDLE  | waiting for a new value (or the post-reset pending request)
// ST_SHIFT | double-dabble running in the bin2bcd datapath
// ST_DONE  | result copied into the display register
module seg_scan_bcd
  import seg_scan_bcd_pkg::*;
#(
  parameter int N_DIG  = 2,
  parameter int DATA_W = 8,
  parameter int DIV    = 10000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic [N_DIG-1:0]  dp_mask,
  input  logic              blank_en,
  output logic              a,
  output logic              b,
  output logic              c,
  output logic              d,
  output logic              e,
  output logic              f,
  output logic              g,
  output logic              dp,
  output logic [N_DIG-1:0]  ds,
  output logic              ovf,
  output logic              busy
);

  localparam int TCK_W = $clog2(DIV);
  localparam int IDX_W = (N_DIG > 1) ? $clog2(N_DIG) : 1;

  if (N_DIG < N_DIG_MIN || N_DIG > N_DIG_MAX || DATA_W < DATA_W_MIN ||
      DATA_W > DATA_W_MAX || DIV < DIV_MIN) begin : g_bad_param
    $error("seg_scan_bcd: illegal parameter combination");
  end

  logic [TCK_W-1:0]   tck_q;
  logic               tick;
  conv_state_t        state_q, state_d;
  logic [DATA_W-1:0]  cap_q, cap_d;
  logic               pending_q, pending_d;
  logic [4*N_DIG-1:0] disp_q, disp_d;
  logic               ovf_q, ovf_d;
  logic               conv_start;
  logic               conv_done;
  logic [4*N_DIG-1:0] conv_bcd;
  logic               conv_ovf;
  logic [IDX_W-1:0]   idx_q;
  logic [N_DIG-1:0]   ds_q;
  logic [6:0]         seg_q;
  logic               dp_q;
  logic [6:0]         seg_sel;
  logic               dp_sel;
  logic [3:0]         dig_sel;
  logic               blank_sel;
  logic               dp_bit;
  logic               upper_zero;

  assign tick = (tck_q == TCK_W'(DIV - 1));

  // Free-running scan prescaler, wraps after the terminal count.
  always_ff @(posedge clk) begin
    if (rst) tck_q <= '0;
    else     tck_q <= tick ? '0 : tck_q + TCK_W'(1);
  end

  // Converter FSM state and capture registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cap_q     <= '0;
      pending_q <= 1'b1;
      disp_q    <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cap_q     <= cap_d;
      pending_q <= pending_d;
      disp_q    <= disp_d;
      ovf_q     <= ovf_d;
    end
  end

  // Next-state logic; busy is forced low while reset is held.
  always_comb begin
    state_d    = state_q;
    cap_d      = cap_q;
    pending_d  = pending_q;
    disp_d     = disp_q;
    ovf_d      = ovf_q;
    conv_start = 1'b0;
    busy       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pending_q || (data_in != cap_q)) begin
          cap_d      = data_in;
          pending_d  = 1'b0;
          conv_start = 1'b1;
          state_d    = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        busy = !rst;
        if (conv_done) state_d = ST_DONE;
      end
      ST_DONE: begin
        busy    = !rst;
        disp_d  = conv_bcd;
        ovf_d   = conv_ovf;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The converter loads data_in directly on the capture edge.
  seg_scan_bcd_bin2bcd #(
    .N_DIG  (N_DIG),
    .DATA_W (DATA_W)
  ) u_bin2bcd (
    .clk     (clk),
    .rst     (rst),
    .start_i (conv_start),
    .value_i (data_in),
    .done_o  (conv_done),
    .bcd_o   (conv_bcd),
    .ovf_o   (conv_ovf)
  );

  // Select the digit at idx and work out blanking from the digits above it.
  always_comb begin
    dig_sel    = 4'd0;
    blank_sel  = 1'b0;
    dp_bit     = 1'b0;
    upper_zero = 1'b1;
    for (int k = N_DIG - 1; k >= 0; k--) begin
      if (disp_q[4*k +: 4] != 4'd0) upper_zero = 1'b0;
      if (IDX_W'(k) == idx_q) begin
        dig_sel   = disp_q[4*k +: 4];
        blank_sel = blank_en && upper_zero && (k != 0);
        dp_bit    = dp_mask[k];
      end
    end
    if (ovf_q) begin
      seg_sel = SEG_MINUS;
      dp_sel  = 1'b0;
    end else if (blank_sel) begin
      seg_sel = SEG_OFF;
      dp_sel  = dp_bit;
    end else begin
      seg_sel = seg_code(dig_sel);
      dp_sel  = dp_bit;
    end
  end

  // On each tick show the current digit, then step idx for the next tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q <= '0;
      ds_q  <= '1;
      seg_q <= SEG_OFF;
      dp_q  <= 1'b0;
    end else if (tick) begin
      ds_q  <= ~(N_DIG'(1) << idx_q);
      seg_q <= seg_sel;
      dp_q  <= dp_sel;
      idx_q <= (idx_q == IDX_W'(N_DIG - 1)) ? '0 : idx_q + IDX_W'(1);
    end
  end

  assign {a, b, c, d, e, f, g} = seg_q;
  assign dp  = dp_q;
  assign ds  = ds_q;
  assign ovf = ovf_q;

endmodule
